// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch
// Description : BCD mm:ss.cc up/down stopwatch with a circular lap buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int LAP_DEPTH = 4,
   parameter bit WRAP      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   input  logic        lap,
   input  logic        load,
   input  logic        mode_down,
   input  logic [23:0] load_value,
   input  logic [3:0]  lap_sel,
   output logic [23:0] display,
   output logic        running,
   output logic        expired,
   output logic [4:0]  lap_count,
   output logic [23:0] lap_data
);

   localparam int             DIV        = CLK_HZ / TICK_HZ;
   localparam int             PW         = $clog2(DIV);
   localparam int             AW         = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
   localparam logic [23:0]    COUNT_MAX  = 24'h595999;
   localparam logic [4:0]     LAP_FULL   = 5'(LAP_DEPTH);
   localparam logic [AW-1:0]  PTR_LAST   = AW'(LAP_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [23:0]     count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            mode_q, mode_d;
   logic [4:0]      lap_count_q, lap_count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [23:0]     laps_q [LAP_DEPTH];
   logic [23:0]     laps_d [LAP_DEPTH];
   logic            tick;
   logic [23:0]     stepped;
   logic [5:0]      rd_sum;
   logic [AW-1:0]   rd_idx;

   // One-unit BCD step; tens of minutes and seconds roll at 5, all others at 9.
   function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic down);
      logic [23:0] r;
      logic        c;
      logic [3:0]  dig;
      logic [3:0]  lim;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         dig = v[4*i +: 4];
         lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (c) begin
            if (down) begin
               if (dig == 4'd0) r[4*i +: 4] = lim;
               else begin
                  r[4*i +: 4] = dig - 4'd1;
                  c           = 1'b0;
               end
            end else begin
               if (dig == lim) r[4*i +: 4] = 4'd0;
               else begin
                  r[4*i +: 4] = dig + 4'd1;
                  c           = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic bcd_legal(input logic [23:0] v);
      logic ok;
      ok = (v[23:20] <= 4'd5) && (v[15:12] <= 4'd5);
      for (int i = 0; i < 6; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign stepped = bcd_step(count_q, mode_q);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      presc_d     = presc_q;
      mode_d      = mode_q;
      lap_count_d = lap_count_q;
      wr_ptr_d    = wr_ptr_q;
      laps_d      = laps_q;

      if (state_q == ST_RUN) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (!mode_q && !WRAP && count_q == COUNT_MAX) count_d = COUNT_MAX;
            else                                          count_d = stepped;
            if (mode_q && stepped == 24'h000000) state_d = ST_EXPIRED;
         end
      end

      // Only the highest-priority asserted command is honoured.
      if (enable) begin
         if (clear) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            presc_d     = '0;
            lap_count_d = '0;
            wr_ptr_d    = '0;
         end else if (start) begin
            if (state_q == ST_IDLE && !(mode_down && count_q == 24'h000000)) begin
               state_d = ST_RUN;
               mode_d  = mode_down;
               presc_d = '0;
            end else if (state_q == ST_PAUSE) begin
               state_d = ST_RUN;
            end
         end else if (pause) begin
            if (state_q == ST_RUN && state_d == ST_RUN) state_d = ST_PAUSE;
         end else if (lap) begin
            if (state_q == ST_RUN || state_q == ST_PAUSE) begin
               laps_d[wr_ptr_q] = count_q;
               wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
               lap_count_d      = (lap_count_q == LAP_FULL) ? lap_count_q : lap_count_q + 5'd1;
            end
         end else if (load) begin
            if (state_q == ST_IDLE && bcd_legal(load_value)) count_d = load_value;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         presc_q     <= '0;
         mode_q      <= 1'b0;
         lap_count_q <= '0;
         wr_ptr_q    <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) laps_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         presc_q     <= presc_d;
         mode_q      <= mode_d;
         lap_count_q <= lap_count_d;
         wr_ptr_q    <= wr_ptr_d;
         laps_q      <= laps_d;
      end
   end

   // Newest entry sits just behind the write pointer.
   always_comb begin
      rd_sum = 6'(wr_ptr_q) + 6'(LAP_DEPTH - 1) - 6'(lap_sel);
      rd_idx = (rd_sum >= 6'(LAP_DEPTH)) ? AW'(rd_sum - 6'(LAP_DEPTH)) : AW'(rd_sum);
   end

   assign lap_data  = ({1'b0, lap_sel} < lap_count_q) ? laps_q[rd_idx] : 24'h000000;
   assign display   = count_q;
   assign running   = (state_q == ST_RUN);
   assign expired   = (state_q == ST_EXPIRED);
   assign lap_count = lap_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_stopwatch
// Description : Self-checking bench for lap_stopwatch, WRAP=1 and WRAP=0 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_stopwatch;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;
   localparam int MAXC  = 359999;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

   logic clk = 1'b0;
   logic reset, enable, start, pause, clear, lap, load, mode_down;
   logic [23:0] load_value;
   logic [3:0]  lap_sel;
   logic [1:0][23:0] o_disp, o_lap;
   logic [1:0]       o_run, o_exp;
   logic [1:0][4:0]  o_lc;

   always #5 clk = ~clk;

   lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(DEPTH), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .pause(pause),
      .clear(clear), .lap(lap), .load(load), .mode_down(mode_down),
      .load_value(load_value), .lap_sel(lap_sel), .display(o_disp[0]),
      .running(o_run[0]), .expired(o_exp[0]), .lap_count(o_lc[0]), .lap_data(o_lap[0]));

   lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(DEPTH), .WRAP(1'b0)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .pause(pause),
      .clear(clear), .lap(lap), .load(load), .mode_down(mode_down),
      .load_value(load_value), .lap_sel(lap_sel), .display(o_disp[1]),
      .running(o_run[1]), .expired(o_exp[1]), .lap_count(o_lc[1]), .lap_data(o_lap[1]));

   int checks = 0;
   int failures = 0;

   // Reference model: count held as plain centiseconds, laps as a newest-first list.
   int m_cnt[2], m_st[2], m_presc[2], m_lc[2];
   bit m_down[2];
   int m_laps[2][DEPTH];

   typedef struct {
      logic [23:0] lv;
      logic [23:0] exp_disp;
   } load_vec_t;

   function automatic logic [23:0] to_bcd(input int c);
      int mn, s, cs;
      mn = c / 6000;
      s  = (c / 100) % 60;
      cs = c % 100;
      return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   function automatic bit bcd_ok(input logic [23:0] v);
      bit ok;
      ok = (v[23:20] <= 4'd5) && (v[15:12] <= 4'd5);
      for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic int from_bcd(input logic [23:0] v);
      return (int'(v[23:20]) * 10 + int'(v[19:16])) * 6000
           + (int'(v[15:12]) * 10 + int'(v[11:8])) * 100
           + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_st[k] = S_IDLE; m_presc[k] = 0; m_lc[k] = 0; m_down[k] = 1'b0;
         for (int j = 0; j < DEPTH; j++) m_laps[k][j] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int st0;
         int prev;
         bit tk;
         st0  = m_st[k];
         prev = m_cnt[k];
         tk   = (st0 == S_RUN) && (m_presc[k] == DIV - 1);
         if (st0 == S_RUN) begin
            m_presc[k] = tk ? 0 : m_presc[k] + 1;
            if (tk) begin
               if (!m_down[k]) m_cnt[k] = (prev == MAXC) ? ((k == 0) ? 0 : MAXC) : prev + 1;
               else begin
                  m_cnt[k] = prev - 1;
                  if (m_cnt[k] == 0) m_st[k] = S_EXP;
               end
            end
         end
         if (enable) begin
            if (clear) begin
               m_st[k] = S_IDLE; m_cnt[k] = 0; m_lc[k] = 0; m_presc[k] = 0;
            end else if (start) begin
               if (st0 == S_IDLE && !(mode_down && prev == 0)) begin
                  m_st[k] = S_RUN; m_down[k] = mode_down; m_presc[k] = 0;
               end else if (st0 == S_PAUSE) m_st[k] = S_RUN;
            end else if (pause) begin
               if (m_st[k] == S_RUN) m_st[k] = S_PAUSE;
            end else if (lap) begin
               if (st0 == S_RUN || st0 == S_PAUSE) begin
                  for (int j = DEPTH - 1; j > 0; j--) m_laps[k][j] = m_laps[k][j-1];
                  m_laps[k][0] = prev;
                  if (m_lc[k] < DEPTH) m_lc[k]++;
               end
            end else if (load) begin
               if (st0 == S_IDLE && bcd_ok(load_value)) m_cnt[k] = from_bcd(load_value);
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         logic [23:0] exp_lap;
         exp_lap = (int'(lap_sel) < m_lc[k]) ? to_bcd(m_laps[k][lap_sel]) : 24'h000000;
         check($sformatf("model.display[%0d]", k), o_disp[k], to_bcd(m_cnt[k]));
         check($sformatf("model.running[%0d]", k), o_run[k], m_st[k] == S_RUN);
         check($sformatf("model.expired[%0d]", k), o_exp[k], m_st[k] == S_EXP);
         check($sformatf("model.lap_count[%0d]", k), o_lc[k], m_lc[k]);
         check($sformatf("model.lap_data[%0d]", k), o_lap[k], exp_lap);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      #1;
      check_model();
   endtask

   task automatic no_cmd();
      start = 0; pause = 0; clear = 0; lap = 0; load = 0;
   endtask

   task automatic do_clear();
      clear = 1; step(); clear = 0;
   endtask

   task automatic do_start();
      start = 1; step(); start = 0;
   endtask

   task automatic do_load(input logic [23:0] v);
      load_value = v; load = 1; step(); load = 0;
   endtask

   load_vec_t vecs[7];

   initial begin
      vecs[0] = '{24'h123456, 24'h123456};
      vecs[1] = '{24'h600000, 24'h123456};
      vecs[2] = '{24'h0A0000, 24'h123456};
      vecs[3] = '{24'h005999, 24'h005999};
      vecs[4] = '{24'h006000, 24'h005999};
      vecs[5] = '{24'h00000A, 24'h005999};
      vecs[6] = '{24'h595999, 24'h595999};

      reset = 1; enable = 1; mode_down = 0; load_value = '0; lap_sel = '0;
      no_cmd();
      model_reset();
      step(); step();
      check("reset.display", o_disp[0], 24'h000000);
      check("reset.running", o_run[0], 1'b0);
      check("reset.expired", o_exp[0], 1'b0);
      check("reset.lap_data", o_lap[0], 24'h000000);
      reset = 0;
      step();

      // Preset table: illegal digits leave the count untouched.
      for (int i = 0; i < 7; i++) begin
         do_load(vecs[i].lv);
         check($sformatf("load_tab%0d.wrap", i), o_disp[0], vecs[i].exp_disp);
         check($sformatf("load_tab%0d.sat", i), o_disp[1], vecs[i].exp_disp);
      end

      // Up count for one second, then pause freezes it.
      do_clear();
      mode_down = 0;
      do_start();
      repeat (1000) step();
      check("up.display", o_disp[0], 24'h000100);
      check("up.running", o_run[0], 1'b1);
      pause = 1; step(); pause = 0;
      repeat (50) step();
      check("pause.display", o_disp[0], 24'h000100);
      check("pause.running", o_run[0], 1'b0);

      // Down count to expiry.
      do_clear();
      do_load(24'h000003);
      mode_down = 1;
      do_start();
      repeat (30) step();
      check("down.display", o_disp[0], 24'h000000);
      check("down.expired", o_exp[0], 1'b1);
      do_start();
      check("exp_start.expired", o_exp[0], 1'b1);
      check("exp_start.running", o_run[0], 1'b0);
      do_clear();
      check("exp_clear.expired", o_exp[0], 1'b0);
      check("exp_clear.running", o_run[0], 1'b0);
      do_start();
      check("down_zero_start.running", o_run[0], 1'b0);
      mode_down = 0;

      // Top-of-range wrap versus saturate.
      do_load(24'h595999);
      do_start();
      repeat (10) step();
      check("wrap.display", o_disp[0], 24'h000000);
      check("sat.display", o_disp[1], 24'h595999);
      check("sat.running", o_run[1], 1'b1);
      repeat (10) step();
      check("wrap2.display", o_disp[0], 24'h000001);
      check("sat2.display", o_disp[1], 24'h595999);

      // Five laps into a four-deep buffer.
      do_clear();
      do_start();
      repeat (10) step();
      for (int k = 1; k <= 5; k++) begin
         lap = 1; step(); lap = 0;
         if (k < 5) repeat (9) step();
      end
      check("laps.count", o_lc[0], 5'd4);
      lap_sel = 4'd0; #1;
      check("laps.sel0", o_lap[0], 24'h000005);
      lap_sel = 4'd3; #1;
      check("laps.sel3", o_lap[0], 24'h000002);
      lap_sel = 4'd4; #1;
      check("laps.sel4", o_lap[0], 24'h000000);
      lap_sel = 4'd0;

      // Simultaneous clear + start + lap, then a disabled start.
      clear = 1; start = 1; lap = 1; step(); no_cmd();
      check("multi.running", o_run[0], 1'b0);
      check("multi.display", o_disp[0], 24'h000000);
      check("multi.lap_count", o_lc[0], 5'd0);
      enable = 0;
      do_start();
      check("disabled.running", o_run[0], 1'b0);
      enable = 1;

      // Asynchronous reset in the middle of a run.
      do_start();
      repeat (25) step();
      lap = 1; step(); lap = 0;
      repeat (3) step();
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      check("async_rst.display", o_disp[0], 24'h000000);
      check("async_rst.running", o_run[0], 1'b0);
      check("async_rst.lap_count", o_lc[0], 5'd0);
      check("async_rst.lap_data", o_lap[0], 24'h000000);
      repeat (3) step();
      @(negedge clk);
      reset = 0;
      repeat (30) step();
      check("post_rst.display", o_disp[0], 24'h000000);
      check("post_rst.running", o_run[0], 1'b0);

      // Random single-command traffic against the model.
      for (int n = 0; n < 6000; n++) begin
         int r;
         int sel;
         no_cmd();
         enable    = ($urandom_range(0, 9) != 0);
         mode_down = 1'($urandom_range(0, 1));
         lap_sel   = 4'($urandom_range(0, 5));
         sel = $urandom_range(0, 3);
         if (sel == 0)      load_value = to_bcd(int'($urandom_range(0, 300)));
         else if (sel == 1) load_value = to_bcd(MAXC - int'($urandom_range(0, 60)));
         else if (sel == 2) load_value = to_bcd(int'($urandom_range(0, MAXC)));
         else               load_value = 24'($urandom);
         r = $urandom_range(0, 99);
         if (r < 1)       clear = 1;
         else if (r < 5)  start = 1;
         else if (r < 7)  pause = 1;
         else if (r < 13) lap   = 1;
         else if (r < 18) load  = 1;
         step();
      end
      no_cmd();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
